// File: rtl/gmii_pkg.sv
// Shared definitions for the GMII receive MAC and the CRC helper.
// The transmit MAC also uses this package.
package gmii_pkg;

  localparam logic [7:0]  ETH_PRE  = 8'h55;
  localparam logic [7:0]  ETH_SFD  = 8'hD5;
  localparam logic [31:0] CRC_POLY = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

  // Framer states.
  // DROP discards the rest of a frame and waits for the carrier to go away.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    PAYLOAD  = 2'd2,
    DROP     = 2'd3
  } rx_state_t;

endpackage

// File: rtl/crc32_byte.sv
// Combinational Ethernet CRC-32 update for one byte.
// Uses the reflected polynomial and consumes the data byte LSB first.
// The register is not inverted here; callers handle the init value and the final complement.
module crc32_byte
  import gmii_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  logic [31:0] crcWork;

  // Fold the byte into the low bits, then run eight reflected shift/xor steps.
  always_comb begin
    crcWork = crc_i ^ {24'h000000, data_i};
    for (int i = 0; i < 8; i++) begin
      if (crcWork[0]) begin
        crcWork = {1'b0, crcWork[31:1]} ^ CRC_POLY;
      end else begin
        crcWork = {1'b0, crcWork[31:1]};
      end
    end
    crc_o = crcWork;
  end

endmodule

// File: rtl/gmii_rx_mac.sv
// GMII receive framer.
// Strips the preamble/SFD, checks the FCS, drops the FCS bytes and streams the
// payload out as a non-stallable AXI-Stream with a bad-frame flag on tlast.
//
// Every byte is delayed through a four-byte shift register and one hold byte.
// When dv falls, the shift register therefore holds exactly the FCS, and the
// hold byte is the final payload byte.
module gmii_rx_mac
  import gmii_pkg::*;
#(
  parameter int MIN_FRAME_LEN = 64,
  parameter int MAX_FRAME_LEN = 1518
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_enable,
  input  logic [7:0] gmii_rxd,
  input  logic       gmii_rx_dv,
  input  logic       gmii_rx_er,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  output logic       m_axis_tlast,
  output logic       m_axis_tuser,
  output logic       stat_good_frame,
  output logic       stat_bad_fcs,
  output logic       stat_bad_frame
);

  localparam logic [10:0] MIN_LEN   = 11'(MIN_FRAME_LEN);
  localparam logic [10:0] MAX_LEN   = 11'(MAX_FRAME_LEN);
  localparam logic [10:0] COUNT_SAT = 11'h7FF;

  rx_state_t state_q, state_d;

  // Cleared by reset.
  // Set by the first enabled cycle with dv low, so that a frame already in
  // flight at reset release is ignored.
  logic armed_q, armed_d;

  logic [7:0]  sr0_q, sr0_d;
  logic [7:0]  sr1_q, sr1_d;
  logic [7:0]  sr2_q, sr2_d;
  logic [7:0]  sr3_q, sr3_d;
  logic [7:0]  hold_q, hold_d;
  logic [31:0] crc_q, crc_d;
  logic [10:0] byteCount_q, byteCount_d;
  logic        errSeen_q, errSeen_d;
  logic        dropReported_q, dropReported_d;

  logic [7:0] tdata_q, tdata_d;
  logic       tvalid_q, tvalid_d;
  logic       tlast_q, tlast_d;
  logic       tuser_q, tuser_d;
  logic       goodPulse_q, goodPulse_d;
  logic       fcsPulse_q, fcsPulse_d;
  logic       framePulse_q, framePulse_d;

  logic [31:0] crcNext;
  logic [31:0] fcsRx;
  logic [10:0] countInc;
  logic        crcBad;
  logic        tooShort;

  // The byte leaving sr3 is the one folded into the running CRC.
  crc32_byte u_crc (
    .crc_i  (crc_q),
    .data_i (sr3_q),
    .crc_o  (crcNext)
  );

  // Signals derived from the current frame state.
  // sr3 is the first FCS byte on the wire, so it forms the least significant byte.
  always_comb begin
    fcsRx    = {sr0_q, sr1_q, sr2_q, sr3_q};
    crcBad   = (~crc_q != fcsRx);
    tooShort = (byteCount_q < MIN_LEN);
    countInc = (byteCount_q == COUNT_SAT) ? byteCount_q : byteCount_q + 11'd1;
  end

  // Next-state, datapath and output logic.
  // Outputs default to idle on every enabled cycle.
  always_comb begin
    state_d        = state_q;
    armed_d        = armed_q;
    sr0_d          = sr0_q;
    sr1_d          = sr1_q;
    sr2_d          = sr2_q;
    sr3_d          = sr3_q;
    hold_d         = hold_q;
    crc_d          = crc_q;
    byteCount_d    = byteCount_q;
    errSeen_d      = errSeen_q;
    dropReported_d = dropReported_q;
    tdata_d        = 8'h00;
    tvalid_d       = 1'b0;
    tlast_d        = 1'b0;
    tuser_d        = 1'b0;
    goodPulse_d    = 1'b0;
    fcsPulse_d     = 1'b0;
    framePulse_d   = 1'b0;

    case (state_q)
      IDLE: begin
        byteCount_d    = 11'd0;
        errSeen_d      = 1'b0;
        dropReported_d = 1'b0;
        crc_d          = CRC_INIT;
        if (!armed_q) begin
          if (!gmii_rx_dv) begin
            armed_d = 1'b1;
          end
        end else if (gmii_rx_dv) begin
          if (gmii_rx_er) begin
            state_d = DROP;
          end else if (gmii_rxd == ETH_PRE) begin
            state_d = PREAMBLE;
          end else if (gmii_rxd == ETH_SFD) begin
            state_d = PAYLOAD;
          end else begin
            state_d = DROP;
          end
        end
      end

      PREAMBLE: begin
        crc_d = CRC_INIT;
        if (!gmii_rx_dv) begin
          state_d      = IDLE;
          framePulse_d = 1'b1;
        end else if (gmii_rx_er) begin
          state_d = DROP;
        end else if (gmii_rxd == ETH_SFD) begin
          state_d = PAYLOAD;
        end else if (gmii_rxd != ETH_PRE) begin
          state_d = DROP;
        end
      end

      PAYLOAD: begin
        if (gmii_rx_dv) begin
          byteCount_d = countInc;
          if (gmii_rx_er) begin
            errSeen_d = 1'b1;
          end
          if (countInc > MAX_LEN) begin
            // Oversized frame: close the stream on the byte already in hold.
            // Report the frame here so that DROP does not report it a second time.
            tdata_d        = hold_q;
            tvalid_d       = 1'b1;
            tlast_d        = 1'b1;
            tuser_d        = 1'b1;
            framePulse_d   = 1'b1;
            dropReported_d = 1'b1;
            state_d        = DROP;
          end else begin
            sr0_d = gmii_rxd;
            sr1_d = sr0_q;
            sr2_d = sr1_q;
            sr3_d = sr2_q;
            if (byteCount_q >= 11'd4) begin
              hold_d = sr3_q;
              crc_d  = crcNext;
            end
            if (byteCount_q >= 11'd5) begin
              tdata_d  = hold_q;
              tvalid_d = 1'b1;
            end
          end
        end else begin
          state_d = IDLE;
          if (byteCount_q >= 11'd5) begin
            tdata_d  = hold_q;
            tvalid_d = 1'b1;
            tlast_d  = 1'b1;
            tuser_d  = crcBad | errSeen_q | tooShort;
            if (crcBad) begin
              fcsPulse_d = 1'b1;
            end else if (errSeen_q || tooShort) begin
              framePulse_d = 1'b1;
            end else begin
              goodPulse_d = 1'b1;
            end
          end else begin
            // The hold byte was never filled, so there is no payload to deliver.
            framePulse_d = 1'b1;
          end
        end
      end

      DROP: begin
        if (!gmii_rx_dv) begin
          state_d = IDLE;
          if (!dropReported_q) begin
            framePulse_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state register; advances only on byte-qualified cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      armed_q <= 1'b0;
    end else if (clk_enable) begin
      state_q <= state_d;
      armed_q <= armed_d;
    end
  end

  // Shift register, hold byte, CRC and per-frame bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr0_q          <= 8'h00;
      sr1_q          <= 8'h00;
      sr2_q          <= 8'h00;
      sr3_q          <= 8'h00;
      hold_q         <= 8'h00;
      crc_q          <= CRC_INIT;
      byteCount_q    <= 11'd0;
      errSeen_q      <= 1'b0;
      dropReported_q <= 1'b0;
    end else if (clk_enable) begin
      sr0_q          <= sr0_d;
      sr1_q          <= sr1_d;
      sr2_q          <= sr2_d;
      sr3_q          <= sr3_d;
      hold_q         <= hold_d;
      crc_q          <= crc_d;
      byteCount_q    <= byteCount_d;
      errSeen_q      <= errSeen_d;
      dropReported_q <= dropReported_d;
    end
  end

  // Output registers.
  // Each holds its value until the next enabled cycle, when the sink samples it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tdata_q      <= 8'h00;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      tuser_q      <= 1'b0;
      goodPulse_q  <= 1'b0;
      fcsPulse_q   <= 1'b0;
      framePulse_q <= 1'b0;
    end else if (clk_enable) begin
      tdata_q      <= tdata_d;
      tvalid_q     <= tvalid_d;
      tlast_q      <= tlast_d;
      tuser_q      <= tuser_d;
      goodPulse_q  <= goodPulse_d;
      fcsPulse_q   <= fcsPulse_d;
      framePulse_q <= framePulse_d;
    end
  end

  // Qualify the outputs with clk_enable.
  // In 10/100 mode a beat or pulse is then visible for exactly one enabled cycle.
  always_comb begin
    m_axis_tdata    = clk_enable ? tdata_q : 8'h00;
    m_axis_tvalid   = clk_enable & tvalid_q;
    m_axis_tlast    = clk_enable & tlast_q;
    m_axis_tuser    = clk_enable & tuser_q;
    stat_good_frame = clk_enable & goodPulse_q;
    stat_bad_fcs    = clk_enable & fcsPulse_q;
    stat_bad_frame  = clk_enable & framePulse_q;
  end

endmodule

// File: tb/tb_gmii_rx_mac.sv
// Directed testbench for gmii_rx_mac: good, corrupted, oversized and runt frames,
// slow clock enable, reset during a frame, and back-to-back frames.
module tb_gmii_rx_mac;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clkEnable = 1'b0;
  logic [7:0] rxd = 8'h00;
  logic       rxDv = 1'b0;
  logic       rxEr = 1'b0;

  logic [7:0] tdata;
  logic       tvalid, tlast, tuser;
  logic       statGood, statFcs, statFrame;

  int nVec = 0;
  int nFail = 0;
  int cycCount = 0;
  bit slowMode = 1'b0;
  int daIdx = 0;
  int daEdge = 0;

  logic [7:0] txQ[$];

  // Captured beats, stored as {tuser, tlast, tdata}, with their cycle numbers.
  logic [9:0] beatQ[$];
  int beatCyc[$];
  int goodCnt = 0;
  int fcsCnt = 0;
  int frameCnt = 0;
  int offEnCnt = 0;

  gmii_rx_mac #(.MIN_FRAME_LEN(64), .MAX_FRAME_LEN(1518)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .clk_enable      (clkEnable),
    .gmii_rxd        (rxd),
    .gmii_rx_dv      (rxDv),
    .gmii_rx_er      (rxEr),
    .m_axis_tdata    (tdata),
    .m_axis_tvalid   (tvalid),
    .m_axis_tlast    (tlast),
    .m_axis_tuser    (tuser),
    .stat_good_frame (statGood),
    .stat_bad_fcs    (statFcs),
    .stat_bad_frame  (statFrame)
  );

  always #5 clk = ~clk;

  // Edge counter: cycCount equals n just after the n-th rising edge.
  always @(posedge clk) cycCount <= cycCount + 1;

  // Mid-cycle monitor: records beats and stat pulses.
  // It also counts any output activity seen while clk_enable is low.
  always @(negedge clk) begin
    if (tvalid) begin
      beatQ.push_back({tuser, tlast, tdata});
      beatCyc.push_back(cycCount);
    end
    if (statGood) goodCnt++;
    if (statFcs) fcsCnt++;
    if (statFrame) frameCnt++;
    if (!clkEnable && (tvalid || tlast || tuser || tdata != 8'h00 || statGood || statFcs || statFrame))
      offEnCnt++;
  end

  // Reference CRC written bit-serially from the Ethernet definition.
  function automatic logic [31:0] crcStep(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    logic fb;
    r = c;
    for (int b = 0; b < 8; b++) begin
      fb = r[0] ^ d[b];
      r = {1'b0, r[31:1]};
      if (fb) r = r ^ 32'hEDB88320;
    end
    return r;
  endfunction

  // Returns the beat at the given index, or all-X when it was never captured.
  function automatic logic [9:0] beatAt(input int idx);
    if (idx < beatQ.size()) return beatQ[idx];
    return 10'bx;
  endfunction

  // Builds a frame: preamble, SFD, a payload of (i + seed), and the FCS sent LSB first.
  task automatic buildFrame(input int nPre, input int nPay, input logic [7:0] seed, input bit flipFcs);
    logic [31:0] crc;
    logic [7:0] b;
    txQ.delete();
    for (int i = 0; i < nPre; i++) txQ.push_back(8'h55);
    txQ.push_back(8'hD5);
    daIdx = nPre + 1;
    crc = 32'hFFFFFFFF;
    for (int i = 0; i < nPay; i++) begin
      b = 8'(i) + seed;
      txQ.push_back(b);
      crc = crcStep(crc, b);
    end
    crc = ~crc;
    for (int k = 0; k < 4; k++) txQ.push_back(crc[8*k +: 8]);
    if (flipFcs) txQ[daIdx + nPay] = txQ[daIdx + nPay] ^ 8'h01;
  endtask

  task automatic driveCycle(input logic en, input logic dv, input logic er, input logic [7:0] d);
    clkEnable = en;
    rxDv = dv;
    rxEr = er;
    rxd = d;
    @(posedge clk);
    #1;
  endtask

  // One byte time. In slow mode, nine disabled cycles come before the enabled cycle.
  task automatic sendByte(input logic dv, input logic er, input logic [7:0] d);
    if (slowMode) for (int k = 0; k < 9; k++) driveCycle(1'b0, dv, er, d);
    driveCycle(1'b1, dv, er, d);
  endtask

  task automatic sendFrame(input int erIdx);
    for (int i = 0; i < txQ.size(); i++) begin
      if (i == daIdx) daEdge = cycCount + (slowMode ? 10 : 1);
      sendByte(1'b1, i == erIdx, txQ[i]);
    end
  endtask

  task automatic sendGap(input int n);
    for (int i = 0; i < n; i++) sendByte(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    driveCycle(1'b1, 1'b0, 1'b0, 8'h00);
    driveCycle(1'b1, 1'b0, 1'b0, 8'h00);
    nVec++; if (tvalid !== 1'b0) begin nFail++; $display("[TB] FAIL reset_tvalid: got %b expected 0", tvalid); end
    nVec++; if (tdata !== 8'h00) begin nFail++; $display("[TB] FAIL reset_tdata: got %h expected 00", tdata); end
    nVec++; if ({tlast, tuser} !== 2'b00) begin nFail++; $display("[TB] FAIL reset_tlast_tuser: got %b expected 00", {tlast, tuser}); end
    nVec++; if ({statGood, statFcs, statFrame} !== 3'b000) begin nFail++; $display("[TB] FAIL reset_stats: got %b expected 000", {statGood, statFcs, statFrame}); end
    rst_n = 1'b1;
    sendGap(3);
    nVec++; if (beatQ.size() !== 0) begin nFail++; $display("[TB] FAIL reset_idle_beats: got %0d expected 0", beatQ.size()); end
  endtask

  task automatic test_good_frame();
    int b0, g0, f0, e0, fc;
    b0 = beatQ.size(); g0 = goodCnt; f0 = fcsCnt; e0 = frameCnt;
    buildFrame(7, 60, 8'h00, 1'b0);
    sendFrame(-1);
    sendGap(4);
    nVec++; if (beatQ.size() - b0 !== 60) begin nFail++; $display("[TB] FAIL good_beat_count: got %0d expected 60", beatQ.size() - b0); end
    for (int i = 0; i < 60; i++) begin
      nVec++;
      if (beatAt(b0 + i) [8:0] !== {i == 59, 8'(i)}) begin
        nFail++; $display("[TB] FAIL good_beat[%0d]: got %h expected %h", i, beatAt(b0 + i) [8:0], {i == 59, 8'(i)});
      end
    end
    nVec++; if (beatAt(b0 + 59) [9] !== 1'b0) begin nFail++; $display("[TB] FAIL good_tuser: got %b expected 0", beatAt(b0 + 59) [9]); end
    fc = (beatQ.size() > b0) ? beatCyc[b0] : -1;
    nVec++; if (fc !== daEdge + 5) begin nFail++; $display("[TB] FAIL good_latency: got cycle %0d expected %0d", fc, daEdge + 5); end
    nVec++; if ({goodCnt - g0, fcsCnt - f0, frameCnt - e0} !== {32'd1, 32'd0, 32'd0}) begin
      nFail++; $display("[TB] FAIL good_stats: got good=%0d fcs=%0d frame=%0d expected 1/0/0", goodCnt - g0, fcsCnt - f0, frameCnt - e0);
    end
  endtask

  task automatic test_bad_fcs();
    int b0, g0, f0, e0;
    b0 = beatQ.size(); g0 = goodCnt; f0 = fcsCnt; e0 = frameCnt;
    buildFrame(7, 60, 8'h00, 1'b1);
    sendFrame(-1);
    sendGap(4);
    nVec++; if (beatQ.size() - b0 !== 60) begin nFail++; $display("[TB] FAIL fcs_beat_count: got %0d expected 60", beatQ.size() - b0); end
    for (int i = 0; i < 60; i++) begin
      nVec++;
      if (beatAt(b0 + i) [8:0] !== {i == 59, 8'(i)}) begin
        nFail++; $display("[TB] FAIL fcs_beat[%0d]: got %h expected %h", i, beatAt(b0 + i) [8:0], {i == 59, 8'(i)});
      end
    end
    nVec++; if (beatAt(b0 + 59) [9] !== 1'b1) begin nFail++; $display("[TB] FAIL fcs_tuser: got %b expected 1", beatAt(b0 + 59) [9]); end
    nVec++; if ({goodCnt - g0, fcsCnt - f0, frameCnt - e0} !== {32'd0, 32'd1, 32'd0}) begin
      nFail++; $display("[TB] FAIL fcs_stats: got good=%0d fcs=%0d frame=%0d expected 0/1/0", goodCnt - g0, fcsCnt - f0, frameCnt - e0);
    end
  endtask

  task automatic test_rx_error();
    int b0, g0, f0, e0;
    b0 = beatQ.size(); g0 = goodCnt; f0 = fcsCnt; e0 = frameCnt;
    buildFrame(7, 60, 8'h00, 1'b0);
    sendFrame(daIdx + 30);
    sendGap(4);
    nVec++; if (beatQ.size() - b0 !== 60) begin nFail++; $display("[TB] FAIL er_beat_count: got %0d expected 60", beatQ.size() - b0); end
    nVec++; if (beatAt(b0 + 59) !== 10'h33B) begin nFail++; $display("[TB] FAIL er_last_beat: got %h expected 33b", beatAt(b0 + 59)); end
    nVec++; if ({goodCnt - g0, fcsCnt - f0, frameCnt - e0} !== {32'd0, 32'd0, 32'd1}) begin
      nFail++; $display("[TB] FAIL er_stats: got good=%0d fcs=%0d frame=%0d expected 0/0/1", goodCnt - g0, fcsCnt - f0, frameCnt - e0);
    end
  endtask

  task automatic test_bad_preamble();
    int b0, g0, f0, e0;
    b0 = beatQ.size(); g0 = goodCnt; f0 = fcsCnt; e0 = frameCnt;
    txQ.delete();
    txQ.push_back(8'h55); txQ.push_back(8'h55); txQ.push_back(8'h5D);
    txQ.push_back(8'h11); txQ.push_back(8'h22); txQ.push_back(8'h33);
    daIdx = 99;
    sendFrame(-1);
    sendGap(3);
    nVec++; if (beatQ.size() - b0 !== 0) begin nFail++; $display("[TB] FAIL pre_beats: got %0d expected 0", beatQ.size() - b0); end
    nVec++; if ({goodCnt - g0, fcsCnt - f0, frameCnt - e0} !== {32'd0, 32'd0, 32'd1}) begin
      nFail++; $display("[TB] FAIL pre_stats: got good=%0d fcs=%0d frame=%0d expected 0/0/1", goodCnt - g0, fcsCnt - f0, frameCnt - e0);
    end
    b0 = beatQ.size(); g0 = goodCnt;
    buildFrame(7, 60, 8'h20, 1'b0);
    sendFrame(-1);
    sendGap(4);
    nVec++; if (beatQ.size() - b0 !== 60) begin nFail++; $display("[TB] FAIL pre_next_count: got %0d expected 60", beatQ.size() - b0); end
    nVec++; if (beatAt(b0 + 59) !== 10'h15B) begin nFail++; $display("[TB] FAIL pre_next_last: got %h expected 15b", beatAt(b0 + 59)); end
    nVec++; if (goodCnt - g0 !== 1) begin nFail++; $display("[TB] FAIL pre_next_good: got %0d expected 1", goodCnt - g0); end
  endtask

  task automatic test_oversize();
    int b0, g0, f0, e0;
    b0 = beatQ.size(); g0 = goodCnt; f0 = fcsCnt; e0 = frameCnt;
    buildFrame(7, 1596, 8'h00, 1'b0);
    sendFrame(-1);
    sendGap(4);
    nVec++; if (beatQ.size() - b0 !== 1514) begin nFail++; $display("[TB] FAIL big_beat_count: got %0d expected 1514", beatQ.size() - b0); end
    for (int i = 0; i < 1514; i++) begin
      nVec++;
      if (beatAt(b0 + i) [8:0] !== {i == 1513, 8'(i)}) begin
        nFail++; $display("[TB] FAIL big_beat[%0d]: got %h expected %h", i, beatAt(b0 + i) [8:0], {i == 1513, 8'(i)});
      end
    end
    nVec++; if (beatAt(b0 + 1513) [9] !== 1'b1) begin nFail++; $display("[TB] FAIL big_tuser: got %b expected 1", beatAt(b0 + 1513) [9]); end
    nVec++; if ({goodCnt - g0, fcsCnt - f0, frameCnt - e0} !== {32'd0, 32'd0, 32'd1}) begin
      nFail++; $display("[TB] FAIL big_stats: got good=%0d fcs=%0d frame=%0d expected 0/0/1", goodCnt - g0, fcsCnt - f0, frameCnt - e0);
    end
  endtask

  task automatic test_runt();
    int b0, g0, f0, e0;
    b0 = beatQ.size(); g0 = goodCnt; f0 = fcsCnt; e0 = frameCnt;
    buildFrame(7, 36, 8'h00, 1'b0);
    sendFrame(-1);
    sendGap(4);
    nVec++; if (beatQ.size() - b0 !== 36) begin nFail++; $display("[TB] FAIL runt_beat_count: got %0d expected 36", beatQ.size() - b0); end
    nVec++; if (beatAt(b0 + 35) !== 10'h323) begin nFail++; $display("[TB] FAIL runt_last_beat: got %h expected 323", beatAt(b0 + 35)); end
    nVec++; if ({goodCnt - g0, fcsCnt - f0, frameCnt - e0} !== {32'd0, 32'd0, 32'd1}) begin
      nFail++; $display("[TB] FAIL runt_stats: got good=%0d fcs=%0d frame=%0d expected 0/0/1", goodCnt - g0, fcsCnt - f0, frameCnt - e0);
    end
  endtask

  task automatic test_slow_enable();
    int b0, g0, o0;
    b0 = beatQ.size(); g0 = goodCnt; o0 = offEnCnt;
    slowMode = 1'b1;
    buildFrame(7, 60, 8'h00, 1'b0);
    sendFrame(-1);
    sendGap(3);
    slowMode = 1'b0;
    nVec++; if (beatQ.size() - b0 !== 60) begin nFail++; $display("[TB] FAIL slow_beat_count: got %0d expected 60", beatQ.size() - b0); end
    for (int i = 0; i < 60; i++) begin
      nVec++;
      if (beatAt(b0 + i) !== {1'b0, i == 59, 8'(i)}) begin
        nFail++; $display("[TB] FAIL slow_beat[%0d]: got %h expected %h", i, beatAt(b0 + i), {1'b0, i == 59, 8'(i)});
      end
    end
    nVec++; if (goodCnt - g0 !== 1) begin nFail++; $display("[TB] FAIL slow_good: got %0d expected 1", goodCnt - g0); end
    nVec++; if (offEnCnt - o0 !== 0) begin nFail++; $display("[TB] FAIL slow_disabled_outputs: got %0d cycles expected 0", offEnCnt - o0); end
  endtask

  task automatic test_reset_mid_frame();
    int b0, g0, f0, e0;
    logic tvBefore;
    buildFrame(7, 60, 8'h00, 1'b0);
    for (int i = 0; i < 28; i++) sendByte(1'b1, 1'b0, txQ[i]);
    b0 = beatQ.size(); g0 = goodCnt; f0 = fcsCnt; e0 = frameCnt;
    tvBefore = tvalid;
    nVec++; if (tvBefore !== 1'b1) begin nFail++; $display("[TB] FAIL midrst_streaming: got %b expected 1", tvBefore); end
    #2;
    rst_n = 1'b0;
    #1;
    nVec++; if ({tvalid, tdata} !== 9'h000) begin nFail++; $display("[TB] FAIL midrst_outputs: got %h expected 000", {tvalid, tdata}); end
    @(posedge clk);
    #1;
    for (int i = 28; i < txQ.size(); i++) begin
      if (i == 31) rst_n = 1'b1;
      sendByte(1'b1, 1'b0, txQ[i]);
    end
    sendGap(4);
    nVec++; if (beatQ.size() - b0 !== 0) begin nFail++; $display("[TB] FAIL midrst_beats: got %0d expected 0", beatQ.size() - b0); end
    nVec++; if ({goodCnt - g0, fcsCnt - f0, frameCnt - e0} !== {32'd0, 32'd0, 32'd0}) begin
      nFail++; $display("[TB] FAIL midrst_stats: got good=%0d fcs=%0d frame=%0d expected 0/0/0", goodCnt - g0, fcsCnt - f0, frameCnt - e0);
    end
  endtask

  task automatic test_back_to_back();
    int b0, g0, f0, e0;
    b0 = beatQ.size(); g0 = goodCnt; f0 = fcsCnt; e0 = frameCnt;
    buildFrame(7, 60, 8'h00, 1'b0);
    sendFrame(-1);
    sendGap(1);
    buildFrame(7, 60, 8'h80, 1'b0);
    sendFrame(-1);
    sendGap(4);
    nVec++; if (beatQ.size() - b0 !== 120) begin nFail++; $display("[TB] FAIL b2b_beat_count: got %0d expected 120", beatQ.size() - b0); end
    for (int i = 0; i < 120; i++) begin
      nVec++;
      if (beatAt(b0 + i) !== {1'b0, i == 59 || i == 119, (i < 60) ? 8'(i) : 8'(i - 60) + 8'h80}) begin
        nFail++; $display("[TB] FAIL b2b_beat[%0d]: got %h", i, beatAt(b0 + i));
      end
    end
    nVec++; if ({goodCnt - g0, fcsCnt - f0, frameCnt - e0} !== {32'd2, 32'd0, 32'd0}) begin
      nFail++; $display("[TB] FAIL b2b_stats: got good=%0d fcs=%0d frame=%0d expected 2/0/0", goodCnt - g0, fcsCnt - f0, frameCnt - e0);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_good_frame();
    test_bad_fcs();
    test_rx_error();
    test_bad_preamble();
    test_oversize();
    test_runt();
    test_slow_enable();
    test_reset_mid_frame();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule

// File: doc/gmii_rx_mac.md
Name: gmii_rx_mac

Overview:
- Receive MAC framer directly downstream of the RGMII PHY receive interface; consumes the de-DDR'd GMII byte stream (8 bits per enabled cycle).
- Strips preamble/SFD, checks the FCS with CRC-32, removes the FCS and emits the payload as a non-stallable AXI-Stream with a frame-error flag.
- Feeds the MAC receive FIFO in the rx clock domain.

Parameters:
- MIN_FRAME_LEN, 64, minimum legal length in bytes from first DA byte through last FCS byte; shorter frames are flagged bad.
- MAX_FRAME_LEN, 1518, maximum legal length in bytes, same span; longer frames are truncated and flagged bad.

Ports:
- clk  in  1  receive clock, phy_rx_clk domain.
- rst_n  in  1  asynchronous, active-low reset.
- clk_enable  in  1  byte qualifier; in 10/100 mode it is high once per assembled byte. All state advances only when it is high.
- gmii_rxd  in  8  received byte.
- gmii_rx_dv  in  1  data valid.
- gmii_rx_er  in  1  receive error.
- m_axis_tdata  out  8  payload byte.
- m_axis_tvalid  out  1  byte valid. There is no tready; the sink must accept every byte.
- m_axis_tlast  out  1  last payload byte.
- m_axis_tuser  out  1  bad frame; valid only with tlast.
- stat_good_frame  out  1  one-cycle pulse per good frame.
- stat_bad_fcs  out  1  one-cycle pulse per FCS mismatch.
- stat_bad_frame  out  1  one-cycle pulse per any other bad or dropped frame.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, CRC set to 0xFFFFFFFF, pipeline and counters cleared. A reset asserted mid-frame discards the frame and emits nothing; after release the block waits for gmii_rx_dv low before it accepts a new frame.
- When clk_enable is low, the state holds and the m_axis/stat outputs are 0.
- FSM transitions (evaluated on enabled cycles):
  - IDLE: dv=1 and rxd=0x55 -> PREAMBLE. dv=1 and rxd=0xD5 -> PAYLOAD. dv=1 with any other byte, or er=1 -> DROP.
  - PREAMBLE: 0x55 -> stay. 0xD5 -> PAYLOAD. Other byte, er=1, or dv=0 -> DROP (dv=0 goes straight to IDLE and pulses stat_bad_frame).
  - PAYLOAD: accept bytes until dv=0, then -> IDLE.
  - DROP: wait for dv=0, then -> IDLE; emit no output.
- Datapath:
  - Four-byte shift register sr0..sr3 feeds a hold register, which feeds the output register.
  - A byte leaving sr3 enters hold and updates the CRC: reflected polynomial 0xEDB88320, init 0xFFFFFFFF, one byte per enabled cycle.
  - When a new byte enters hold, the old hold byte goes to the output with tvalid=1, tlast=0.
- End of frame (first enabled cycle with dv=0 in PAYLOAD):
  - hold goes to the output with tlast=1.
  - FCS = {sr0,sr1,sr2,sr3}, with sr3 as the LSB (first FCS byte).
  - tuser=1 if any of the following: ~crc != FCS, er was seen during the frame, byte count < MIN_FRAME_LEN.
  - Exactly one stat pulse fires, in the same cycle, with priority bad_fcs > bad_frame > good.
- Latency: a byte sampled at edge e is visible on m_axis after edge e+5. tlast is visible one enabled cycle after dv=0 is sampled.
- Frames ending with fewer than 5 post-SFD bytes (hold never filled): no output beats, stat_bad_frame pulses.
- Byte count is 11 bits and saturates. When it reaches MAX_FRAME_LEN+1:
  - The current hold byte is emitted with tlast=1, tuser=1.
  - stat_bad_frame pulses and the FSM goes to DROP.
  - No CRC check is performed.
- gmii_rx_er with dv=0 is ignored (carrier extension/false carrier).
- Back-to-back frames: an IDLE gap of one enabled cycle between frames is sufficient.

Decomposition:
- Package gmii_pkg holds:
  - constants ETH_PRE=0x55, ETH_SFD=0xD5, CRC_POLY=0xEDB88320, CRC_INIT=0xFFFFFFFF.
  - the enum rx_state_t {IDLE, PREAMBLE, PAYLOAD, DROP}.
- One sub-module, crc32_byte: a combinational next-CRC from (crc_in, data byte). It is reused by the transmit MAC.

Test Plan:
- 7x 0x55, 0xD5, 60-byte payload 0x00..0x3B, correct FCS, clk_enable=1 -> 60 beats 0x00..0x3B; tlast on 0x3B; tuser=0; one stat_good_frame pulse; first beat 5 cycles after the first DA sample.
- Same frame with FCS LSB flipped -> identical data beats, tuser=1 on the last beat, stat_bad_fcs pulse only.
- gmii_rx_er=1 for one cycle mid-payload with a correct FCS -> tuser=1 on the last beat, stat_bad_frame pulse.
- Preamble 0x55,0x55,0x5D -> no beats; dv drop -> stat_bad_frame pulse; the next valid frame is received good.
- 1600-byte frame -> 1514 beats, tlast+tuser on beat 1514, stat_bad_frame pulse, no further beats until the next frame; a 40-byte runt with a valid FCS -> 36 beats, tuser=1.
- clk_enable toggling 1-of-10 (100 Mb/s) with the first scenario's frame -> identical beat sequence; outputs asserted only on enabled cycles. rst_n pulsed mid-payload -> outputs 0 immediately, no tlast emitted.
